// File: rtl/riscv_io_pkg.sv
// rtl/riscv_io_pkg.sv - address map constants and shared enums for the data bus bridge
package riscv_io_pkg;

  localparam logic [31:0] DEF_DATA_START_ADDRESS = 32'h0000_2000;
  localparam logic [31:0] DEF_DATA_SIZE_BYTES    = 32'd8192;
  localparam logic [31:0] DEF_IO_START_ADDRESS   = 32'h0000_7f00;
  localparam logic [31:0] DEF_VGA_START_ADDRESS  = 32'h0000_8000;
  localparam logic [31:0] DEF_VGA_SIZE_BYTES     = 32'h0000_8000;

  localparam logic [7:0]  ERR_COUNT_MAX = 8'hFF;

  // Which target an address falls into; I/O and VGA share the I/O subsystem
  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_DMEM,
    REGION_IO
  } region_t;

  // Read-tracking state: what the previous cycle's read was aimed at
  typedef enum logic [1:0] {
    IDLE,
    RD_DMEM,
    RD_IO,
    RD_ERR
  } rd_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational region and alignment decode of a byte address
module bus_addr_decode
  import riscv_io_pkg::*;
#(
  parameter logic [31:0] DATA_START_ADDRESS = DEF_DATA_START_ADDRESS,
  parameter logic [31:0] DATA_SIZE_BYTES    = DEF_DATA_SIZE_BYTES,
  parameter logic [31:0] IO_START_ADDRESS   = DEF_IO_START_ADDRESS,
  parameter logic [31:0] VGA_START_ADDRESS  = DEF_VGA_START_ADDRESS,
  parameter logic [31:0] VGA_SIZE_BYTES     = DEF_VGA_SIZE_BYTES
) (
  input  logic [31:0] address,
  output region_t     region,
  output logic        aligned
);

  // Upper bounds are exclusive; VGA directly follows the I/O registers
  localparam logic [31:0] DATA_END = DATA_START_ADDRESS + DATA_SIZE_BYTES;
  localparam logic [31:0] IO_END   = VGA_START_ADDRESS + VGA_SIZE_BYTES;

  // Region lookup, DMEM checked first so an overlapping map favours memory
  always_comb begin
    region = REGION_NONE;
    if (address >= DATA_START_ADDRESS && address < DATA_END) begin
      region = REGION_DMEM;
    end else if (address >= IO_START_ADDRESS && address < IO_END) begin
      region = REGION_IO;
    end
  end

  assign aligned = (address[1:0] == 2'b00);

endmodule

// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - routes processor data accesses to DMEM or I/O and logs illegal ones
module data_bus_bridge
  import riscv_io_pkg::*;
#(
  parameter logic [31:0] DATA_START_ADDRESS = DEF_DATA_START_ADDRESS,
  parameter logic [31:0] DATA_SIZE_BYTES    = DEF_DATA_SIZE_BYTES,
  parameter logic [31:0] IO_START_ADDRESS   = DEF_IO_START_ADDRESS,
  parameter logic [31:0] VGA_START_ADDRESS  = DEF_VGA_START_ADDRESS,
  parameter logic [31:0] VGA_SIZE_BYTES     = DEF_VGA_SIZE_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        dmem_write,
  input  logic [31:0] dmem_read_data,
  output logic        io_read,
  output logic        io_write,
  input  logic [31:0] io_read_data,
  input  logic        io_valid,
  output logic        bus_error,
  output logic [31:0] err_address,
  output logic [7:0]  err_count,
  input  logic        err_clear
);

  region_t   region;
  logic      aligned;
  logic      access;
  logic      illegal;
  logic      legal;
  rd_state_t state;

  bus_addr_decode #(
    .DATA_START_ADDRESS (DATA_START_ADDRESS),
    .DATA_SIZE_BYTES    (DATA_SIZE_BYTES),
    .IO_START_ADDRESS   (IO_START_ADDRESS),
    .VGA_START_ADDRESS  (VGA_START_ADDRESS),
    .VGA_SIZE_BYTES     (VGA_SIZE_BYTES)
  ) u_decode (
    .address (dAddress),
    .region  (region),
    .aligned (aligned)
  );

  // An access is only judged when a strobe is up; simultaneous read+write is never legal
  assign access  = MemRead | MemWrite;
  assign illegal = access & ((region == REGION_NONE) | ~aligned | (MemRead & MemWrite));
  assign legal   = access & ~illegal;

  // Strobes pass straight through in the request cycle, held off during reset
  assign dmem_write = ~rst & legal & MemWrite & (region == REGION_DMEM);
  assign io_write   = ~rst & legal & MemWrite & (region == REGION_IO);
  assign io_read    = ~rst & legal & MemRead  & (region == REGION_IO);

  // Read tracker: remembers last cycle's read target so the returned data can be steered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (MemRead) begin
      if (illegal) begin
        state <= RD_ERR;
      end else if (region == REGION_DMEM) begin
        state <= RD_DMEM;
      end else begin
        state <= RD_IO;
      end
    end else begin
      state <= IDLE;
    end
  end

  // Return-data mux; zero for idle, errored reads, invalid I/O data and while in reset
  always_comb begin
    dReadData = 32'h0;
    if (!rst) begin
      case (state)
        RD_DMEM: dReadData = dmem_read_data;
        RD_IO:   dReadData = io_valid ? io_read_data : 32'h0;
        default: dReadData = 32'h0;
      endcase
    end
  end

  // Error log: one-cycle pulse, first-offender address, saturating count; clear beats the log
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_error   <= 1'b0;
      err_address <= 32'h0;
      err_count   <= 8'h0;
    end else begin
      bus_error <= illegal;
      if (err_clear) begin
        err_address <= illegal ? dAddress : 32'h0;
        err_count   <= illegal ? 8'd1 : 8'd0;
      end else if (illegal) begin
        if (err_count == 8'h0) begin
          err_address <= dAddress;
        end
        if (err_count != ERR_COUNT_MAX) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - directed self-checking bench for data_bus_bridge
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dAddress;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dReadData;
  logic        dmem_write;
  logic [31:0] dmem_read_data;
  logic        io_read;
  logic        io_write;
  logic [31:0] io_read_data;
  logic        io_valid;
  logic        bus_error;
  logic [31:0] err_address;
  logic [7:0]  err_count;
  logic        err_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .dAddress       (dAddress),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .dReadData      (dReadData),
    .dmem_write     (dmem_write),
    .dmem_read_data (dmem_read_data),
    .io_read        (io_read),
    .io_write       (io_write),
    .io_read_data   (io_read_data),
    .io_valid       (io_valid),
    .bus_error      (bus_error),
    .err_address    (err_address),
    .err_count      (err_count),
    .err_clear      (err_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b_addr [10] = '{32'h3ffc, 32'h4000, 32'h1ffc, 32'h2000, 32'h7efc,
                               32'h7f00, 32'h7ffc, 32'h8000, 32'hfffc, 32'h10000};
  logic        b_dmem [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        b_io   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; dAddress = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    dmem_read_data = 32'h0; io_read_data = 32'h0; io_valid = 1'b0; err_clear = 1'b0;

    // Strobes held off during reset
    cyc();
    dAddress = 32'h2000; MemWrite = 1'b1; #1;
    chk("rst_dmem_write", {31'h0, dmem_write}, 32'h0);
    dAddress = 32'h7f00; MemWrite = 1'b0; MemRead = 1'b1; #1;
    chk("rst_io_read", {31'h0, io_read}, 32'h0);
    MemWrite = 1'b1; MemRead = 1'b0; #1;
    chk("rst_io_write", {31'h0, io_write}, 32'h0);
    MemWrite = 1'b0;
    cyc();
    chk("rst_rdata", dReadData, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst_err_address", err_address, 32'h0);
    chk("rst_err_count", {24'h0, err_count}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("idle_rdata", dReadData, 32'h0);

    // DMEM read, one-cycle latency
    dAddress = 32'h2004; MemRead = 1'b1; #1;
    chk("dmem_rd_io_read", {31'h0, io_read}, 32'h0);
    chk("dmem_rd_dmem_write", {31'h0, dmem_write}, 32'h0);
    cyc();
    MemRead = 1'b0; dmem_read_data = 32'h12345678; #1;
    chk("dmem_rd_data", dReadData, 32'h12345678);
    chk("dmem_rd_bus_error", {31'h0, bus_error}, 32'h0);

    // I/O write then I/O read
    dAddress = 32'h7f08; MemWrite = 1'b1; #1;
    chk("io_wr_io_write", {31'h0, io_write}, 32'h1);
    chk("io_wr_dmem_write", {31'h0, dmem_write}, 32'h0);
    cyc();
    MemWrite = 1'b0; MemRead = 1'b1; #1;
    chk("io_rd_io_read", {31'h0, io_read}, 32'h1);
    chk("io_rd_dmem_write", {31'h0, dmem_write}, 32'h0);
    cyc();
    MemRead = 1'b0; io_read_data = 32'hA5; io_valid = 1'b0; #1;
    chk("io_rd_not_valid", dReadData, 32'h0);
    io_valid = 1'b1; #1;
    chk("io_rd_data", dReadData, 32'hA5);
    dAddress = 32'h2008; MemWrite = 1'b1; #1;
    chk("dmem_wr_dmem_write", {31'h0, dmem_write}, 32'h1);
    chk("dmem_wr_io_write", {31'h0, io_write}, 32'h0);
    cyc();
    MemWrite = 1'b0; io_valid = 1'b0;

    // Unmapped read
    dAddress = 32'h5000; MemRead = 1'b1; #1;
    chk("unmapped_io_read", {31'h0, io_read}, 32'h0);
    cyc();
    MemRead = 1'b0; dmem_read_data = 32'hFFFFFFFF; io_read_data = 32'hCAFEF00D; io_valid = 1'b1; #1;
    chk("unmapped_rdata", dReadData, 32'h0);
    chk("unmapped_bus_error", {31'h0, bus_error}, 32'h1);
    chk("unmapped_err_address", err_address, 32'h5000);
    chk("unmapped_err_count", {24'h0, err_count}, 32'h1);
    io_valid = 1'b0;
    cyc();
    chk("bus_error_one_cycle", {31'h0, bus_error}, 32'h0);
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0; #1;
    chk("clear_err_count", {24'h0, err_count}, 32'h0);
    chk("clear_err_address", err_address, 32'h0);

    // Misaligned write, then saturation
    dAddress = 32'h2002; MemWrite = 1'b1; #1;
    chk("misaligned_dmem_write", {31'h0, dmem_write}, 32'h0);
    chk("misaligned_io_write", {31'h0, io_write}, 32'h0);
    cyc();
    MemWrite = 1'b0; #1;
    chk("misaligned_err_count", {24'h0, err_count}, 32'h1);
    chk("misaligned_err_address", err_address, 32'h2002);
    chk("misaligned_bus_error", {31'h0, bus_error}, 32'h1);
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       begin dAddress = 32'h5000; MemRead = 1'b0; MemWrite = 1'b1; end
        1:       begin dAddress = 32'h2001; MemRead = 1'b1; MemWrite = 1'b0; end
        default: begin dAddress = 32'h2000; MemRead = 1'b1; MemWrite = 1'b1; end
      endcase
      cyc();
    end
    MemRead = 1'b0; MemWrite = 1'b0; #1;
    chk("sat_err_count", {24'h0, err_count}, 32'hFF);
    chk("sat_err_address", err_address, 32'h2002);

    // Region boundaries, write strobes
    for (int i = 0; i < 10; i++) begin
      dAddress = b_addr[i]; MemWrite = 1'b1; #1;
      chk($sformatf("bound_dmem_write_%h", b_addr[i]), {31'h0, dmem_write}, {31'h0, b_dmem[i]});
      chk($sformatf("bound_io_write_%h", b_addr[i]), {31'h0, io_write}, {31'h0, b_io[i]});
      cyc();
    end
    MemWrite = 1'b0;
    dAddress = 32'h8000; MemRead = 1'b1; #1;
    chk("vga_io_read", {31'h0, io_read}, 32'h1);
    cyc();

    // Simultaneous read and write at a legal address
    dAddress = 32'h2000; MemRead = 1'b1; MemWrite = 1'b1; #1;
    chk("rw_dmem_write", {31'h0, dmem_write}, 32'h0);
    cyc();
    MemRead = 1'b0; MemWrite = 1'b0; dmem_read_data = 32'h99999999; #1;
    chk("rw_rdata", dReadData, 32'h0);
    chk("rw_bus_error", {31'h0, bus_error}, 32'h1);
    cyc();

    // Back-to-back reads DMEM, IO, DMEM
    dAddress = 32'h2000; MemRead = 1'b1;
    cyc();
    dAddress = 32'h7f00; dmem_read_data = 32'h11111111; #1;
    chk("b2b_first", dReadData, 32'h11111111);
    cyc();
    dAddress = 32'h2010; io_valid = 1'b1; io_read_data = 32'h22222222; dmem_read_data = 32'h33333333; #1;
    chk("b2b_second", dReadData, 32'h22222222);
    cyc();
    MemRead = 1'b0; io_valid = 1'b0; dmem_read_data = 32'h44444444; #1;
    chk("b2b_third", dReadData, 32'h44444444);
    cyc();
    chk("b2b_idle", dReadData, 32'h0);

    // Reset with a read in flight
    dAddress = 32'h2000; MemRead = 1'b1;
    cyc();
    MemRead = 1'b0; rst = 1'b1; dmem_read_data = 32'hDEADBEEF; #1;
    chk("rst_inflight_rdata", dReadData, 32'h0);
    cyc();
    rst = 1'b0; #1;
    chk("after_rst_rdata", dReadData, 32'h0);
    chk("after_rst_err_count", {24'h0, err_count}, 32'h0);
    chk("after_rst_bus_error", {31'h0, bus_error}, 32'h0);

    // First-offender hold, then clear racing an illegal access
    dAddress = 32'h6000; MemRead = 1'b1;
    cyc();
    dAddress = 32'h6004; #1;
    chk("first_err_count", {24'h0, err_count}, 32'h1);
    chk("first_err_address", err_address, 32'h6000);
    cyc();
    MemRead = 1'b0; #1;
    chk("second_err_count", {24'h0, err_count}, 32'h2);
    chk("second_err_address", err_address, 32'h6000);
    err_clear = 1'b1; dAddress = 32'h5004; MemWrite = 1'b1; #1;
    chk("clear_race_dmem_write", {31'h0, dmem_write}, 32'h0);
    chk("clear_race_io_write", {31'h0, io_write}, 32'h0);
    cyc();
    err_clear = 1'b0; MemWrite = 1'b0; #1;
    chk("clear_race_err_count", {24'h0, err_count}, 32'h1);
    chk("clear_race_err_address", err_address, 32'h5004);
    chk("clear_race_bus_error", {31'h0, bus_error}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
